// File: rtl/mfp_uart_transmitter_pkg.sv
// Shared 8N1 UART constants and FSM state encoding, reusable by the receiver.
// Pure declarations: no logic, no latency, no flow control.
package mfp_uart_transmitter_pkg;
  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;
endpackage

// File: rtl/mfp_uart_tx_fifo.sv
// Circular byte FIFO; head entry readable combinationally, state updates one edge after push/pop.
// Pushes while full are dropped (writer must watch full); pops while empty are ignored.
module mfp_uart_tx_fifo
  import mfp_uart_transmitter_pkg::*;
#(
  parameter int FIFO_DEPTH_LOG2 = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 push,
  input  logic [DATA_BITS-1:0] push_data,
  input  logic                 pop,
  output logic [DATA_BITS-1:0] pop_data,
  output logic                 empty,
  output logic                 full
);
  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;

  logic [DATA_BITS-1:0]     mem_q [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_q;
  logic [FIFO_DEPTH_LOG2-1:0] rd_ptr_q;
  logic [FIFO_DEPTH_LOG2:0]   count_q;
  logic                       do_push;
  logic                       do_pop;

  assign full     = (count_q == (FIFO_DEPTH_LOG2 + 1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem_q[rd_ptr_q];

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  // Pointers wrap naturally at DEPTH since DEPTH is a power of two.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: rtl/mfp_uart_transmitter.sv
// 8N1 UART transmitter fed by a small FIFO; tx falls the edge after the FIFO pop, 10*DIV cycles per frame.
// wr_ready drops only while the FIFO is full; frames run back-to-back while data is queued.
module mfp_uart_transmitter
  import mfp_uart_transmitter_pkg::*;
#(
  parameter int CLOCK_FREQUENCY = 50_000_000,
  parameter int BAUD_RATE       = 115200,
  parameter int FIFO_DEPTH_LOG2 = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 wr_valid,
  input  logic [DATA_BITS-1:0] wr_data,
  output logic                 wr_ready,
  output logic                 tx,
  output logic                 busy
);
  localparam int DIV    = CLOCK_FREQUENCY / BAUD_RATE;
  localparam int BAUD_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IDX_W  = $clog2(DATA_BITS);

  generate
    if (DIV < 2) begin : g_div_check
      $error("mfp_uart_transmitter: CLOCK_FREQUENCY / BAUD_RATE must be at least 2");
    end
  endgenerate

  uart_state_e          state_q;
  logic [BAUD_W-1:0]    baud_q;
  logic [IDX_W-1:0]     idx_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 tx_q;

  logic                 fifo_pop;
  logic                 fifo_empty;
  logic                 fifo_full;
  logic [DATA_BITS-1:0] fifo_data;
  logic                 baud_end;
  logic                 stop_done;

  mfp_uart_tx_fifo #(
    .FIFO_DEPTH_LOG2(FIFO_DEPTH_LOG2)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (wr_valid),
    .push_data(wr_data),
    .pop      (fifo_pop),
    .pop_data (fifo_data),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  assign baud_end  = (baud_q == BAUD_W'(DIV - 1));
  assign stop_done = (state_q == ST_STOP) && baud_end && (idx_q == IDX_W'(STOP_BITS - 1));
  // Popping at the end of STOP is what makes consecutive frames gapless.
  assign fifo_pop  = !fifo_empty && ((state_q == ST_IDLE) || stop_done);

  assign wr_ready = !fifo_full;
  assign busy     = (state_q != ST_IDLE) || !fifo_empty;
  assign tx       = tx_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      baud_q <= (state_q == ST_IDLE || baud_end) ? '0 : baud_q + 1'b1;
      case (state_q)
        ST_START: begin
          if (baud_end) begin
            state_q <= ST_DATA;
            idx_q   <= '0;
            tx_q    <= shift_q[0];
          end
        end
        ST_DATA: begin
          if (baud_end) begin
            if (idx_q == IDX_W'(DATA_BITS - 1)) begin
              state_q <= ST_STOP;
              idx_q   <= '0;
              tx_q    <= 1'b1;
            end else begin
              shift_q <= shift_q >> 1;
              idx_q   <= idx_q + 1'b1;
              tx_q    <= shift_q[1];
            end
          end
        end
        ST_STOP: begin
          if (stop_done) begin
            if (fifo_pop) begin
              state_q <= ST_START;
              shift_q <= fifo_data;
              tx_q    <= 1'b0;
            end else begin
              state_q <= ST_IDLE;
              tx_q    <= 1'b1;
            end
          end else if (baud_end) begin
            idx_q <= idx_q + 1'b1;
          end
        end
        default: begin
          tx_q <= 1'b1;
          if (fifo_pop) begin
            state_q <= ST_START;
            shift_q <= fifo_data;
            tx_q    <= 1'b0;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mfp_uart_transmitter.sv
// Directed bench for mfp_uart_transmitter at DIV=16 with a byte scoreboard fed by a line-level receiver.
// Exact-cycle waveform checks for a single frame, plus FIFO full, reset abort and wrap-around streams.
module tb_mfp_uart_transmitter;
  logic       clock;
  logic       reset;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic       wr_ready;
  logic       tx;
  logic       busy;

  int         total = 0;
  int         bad = 0;
  int         gen = 0;
  int         rx_cnt = 0;
  int         pushed = 0;
  logic [7:0] sb[$];

  mfp_uart_transmitter #(
    .CLOCK_FREQUENCY(1_600_000),
    .BAUD_RATE      (100_000),
    .FIFO_DEPTH_LOG2(2)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .wr_valid(wr_valid),
    .wr_data (wr_data),
    .wr_ready(wr_ready),
    .tx      (tx),
    .busy    (busy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Offers one byte until accepted (bounded); returns how many cycles it was held off.
  task automatic write_byte(input logic [7:0] b, output int waited);
    logic acc;
    acc      = 1'b0;
    waited   = 0;
    wr_valid = 1'b1;
    wr_data  = b;
    while (!acc && waited < 1000) begin
      acc = wr_ready;
      tick();
      if (!acc) waited++;
    end
    wr_valid = 1'b0;
    chk("wr_accept", acc, 1);
    if (acc) begin
      sb.push_back(b);
      pushed++;
    end
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 5000) begin
      tick();
      n++;
    end
    chk(tag, busy, 0);
  endtask

  // Line receiver: samples mid-bit on the falling clock edge.
  initial begin : monitor
    logic       prev;
    logic       st;
    logic [7:0] rb;
    logic [7:0] exp;
    int         g;
    prev = 1'b1;
    forever begin
      @(negedge clock);
      if (prev === 1'b1 && tx === 1'b0) begin
        g = gen;
        repeat (8) @(negedge clock);
        st = tx;
        for (int b = 0; b < 8; b++) begin
          repeat (16) @(negedge clock);
          rb[b] = tx;
        end
        repeat (16) @(negedge clock);
        if (g == gen) begin
          chk("rx_start_mid", st, 0);
          chk("rx_stop_mid", tx, 1);
          total++;
          assert (sb.size() > 0) else begin
            bad++;
            $error("FAIL rx_unexpected_frame observed=%02h expected=none", rb);
          end
          if (sb.size() > 0) begin
            exp = sb.pop_front();
            chk("rx_byte", rb, exp);
          end
          rx_cnt++;
        end
      end
      prev = tx;
    end
  end

  initial begin
    int         w;
    int         n;
    int         bp;
    int         lowcnt;
    int         rx_snap;
    logic       e;
    logic [7:0] d;

    reset    = 1'b1;
    wr_valid = 1'b0;
    wr_data  = 8'h00;
    repeat (3) tick();
    chk("rst_tx", tx, 1);
    chk("rst_wr_ready", wr_ready, 1);
    chk("rst_busy", busy, 0);
    reset = 1'b0;
    tick();
    chk("idle_tx", tx, 1);

    // Single byte with exact-cycle waveform
    d = 8'hA5;
    write_byte(d, w);
    chk("a5_tx_still_idle", tx, 1);
    chk("a5_busy_rise", busy, 1);
    for (int j = 0; j < 160; j++) begin
      tick();
      bp = j / 16;
      e  = (bp == 0) ? 1'b0 : (bp == 9) ? 1'b1 : d[bp-1];
      chk("a5_frame_bit", tx, e);
      if (j == 159) chk("a5_busy_last_stop", busy, 1);
    end
    tick();
    chk("a5_busy_fall", busy, 0);
    chk("a5_tx_idle", tx, 1);

    // Back-to-back frames
    write_byte(8'h00, w);
    write_byte(8'hFF, w);
    chk("b2b_no_wait", w, 0);
    n = 0;
    while (tx !== 1'b0 && n < 50) begin
      tick();
      n++;
    end
    chk("b2b_start_seen", tx, 0);
    n = 0;
    while (busy && n < 1000) begin
      tick();
      n++;
    end
    chk("b2b_active_cycles", n, 320);

    // FIFO full while the FSM is mid-frame
    write_byte(8'hC3, w);
    repeat (5) tick();
    for (int k = 0; k < 4; k++) begin
      write_byte(8'h50 + 8'(k), w);
      chk("full_fill_no_wait", w, 0);
      chk("full_wr_ready_after_accept", wr_ready, (k < 3) ? 1 : 0);
    end
    write_byte(8'h54, w);
    chk("full_fifth_held", (w > 100), 1);

    // Full again: a write while not ready must be dropped
    wr_valid = 1'b1;
    wr_data  = 8'h77;
    for (int i = 0; i < 20; i++) begin
      chk("ignored_wr_ready_low", wr_ready, 0);
      tick();
    end
    wr_valid = 1'b0;
    wait_idle("full_drain_timeout");
    repeat (4) tick();
    chk("full_sb_empty", sb.size(), 0);
    chk("full_rx_count", rx_cnt, pushed);

    // Reset during bit 3 of 0x3C with bytes queued behind it
    write_byte(8'h3C, w);
    write_byte(8'h11, w);
    write_byte(8'h22, w);
    repeat (69) tick();
    chk("abort_bit3_value", tx, 1);
    reset = 1'b1;
    gen++;
    pushed -= sb.size();
    sb.delete();
    rx_snap = rx_cnt;
    tick();
    chk("abort_tx", tx, 1);
    chk("abort_busy", busy, 0);
    chk("abort_wr_ready", wr_ready, 1);
    reset  = 1'b0;
    lowcnt = 0;
    for (int i = 0; i < 250; i++) begin
      tick();
      if (tx !== 1'b1 || busy !== 1'b0) lowcnt++;
    end
    chk("abort_no_more_frames", lowcnt, 0);
    chk("abort_rx_count", rx_cnt, rx_snap);

    // Wrap-around stream with random gaps
    for (int i = 1; i <= 12; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      write_byte(8'(i), w);
    end
    wait_idle("wrap_drain_timeout");
    repeat (4) tick();
    chk("wrap_sb_empty", sb.size(), 0);
    chk("final_rx_count", rx_cnt, pushed);
    chk("final_tx_idle", tx, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
